// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: sequences one timestep of the Izhikevich neuron core.
// Sweeps every neuron tag through the state register / Izhikevich pipeline,
// issues write-backs delayed by the pipeline latency, waits for the spike FIFO
// and compute-in-memory array to drain, then pulses the current-buffer swap.
// Optional feature: define SCHED_AUTORUN_EN to chain timesteps back-to-back
// while in_start is held high.
`timescale 1ns / 1ps

module neuron_update_scheduler #(
  parameter int unsigned numneurons   = 2,
  parameter int unsigned tagbits      = 1,
  parameter int unsigned pipe_latency = 3   // legal range 1..15
) (
  input  logic               in_clk,
  input  logic               in_asyn_reset,
  input  logic               in_start,
  input  logic               in_cim_busy,
  input  logic               in_fifo_empty,
  output logic [tagbits-1:0] out_rd_tag,
  output logic               out_issue_valid,
  output logic [tagbits-1:0] out_wb_tag,
  output logic               out_sr_write_en,
  output logic               out_swap,
  output logic               out_done,
  output logic               out_busy,
  output logic [15:0]        out_timestep
);

  // One extra bit so the counter can reach numneurons, meaning "all issued".
  localparam int unsigned    CntW    = tagbits + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(numneurons);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StWaitSpikes,
    StSwap
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                issue_valid_q;
  logic [tagbits-1:0]  rd_tag_q;
  logic                swap_q;
  logic                done_q;
  logic                busy_q;
  logic [15:0]         timestep_q;

  // Delay line: entry i holds the issue from i+1 cycles ago.
  logic [pipe_latency-1:0] dl_valid_q;
  logic [tagbits-1:0]      dl_tag_q [pipe_latency];

  logic dl_pending;
  logic restart;

  // Chain straight into the next timestep only when autorun is built in.
`ifdef SCHED_AUTORUN_EN
  assign restart = in_start;
`else
  assign restart = 1'b0;
`endif

  // Any issue still in flight apart from the one being written back this cycle.
  always_comb begin
    dl_pending = issue_valid_q;
    for (int i = 0; i < int'(pipe_latency) - 1; i++) begin
      dl_pending = dl_pending | dl_valid_q[i];
    end
  end

  // Scheduler FSM with registered, state-decoded outputs.
  always_ff @(posedge in_clk or posedge in_asyn_reset) begin
    if (in_asyn_reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      rd_tag_q      <= '0;
      swap_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      timestep_q    <= '0;
    end else begin
      issue_valid_q <= 1'b0;
      swap_q        <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_start) begin
            state_q <= StIssue;
            busy_q  <= 1'b1;
            // Tag 0 goes out in the first ISSUE cycle unless the array is busy.
            if (!in_cim_busy) begin
              issue_valid_q <= 1'b1;
              rd_tag_q      <= '0;
              cnt_q         <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
        end
        StIssue: begin
          if (cnt_q == LastCnt) begin
            state_q <= StDrain;
          end else if (!in_cim_busy) begin
            issue_valid_q <= 1'b1;
            rd_tag_q      <= cnt_q[tagbits-1:0];
            cnt_q         <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (!dl_pending) begin
            state_q <= StWaitSpikes;
          end
        end
        StWaitSpikes: begin
          if (in_fifo_empty && !in_cim_busy) begin
            state_q    <= StSwap;
            swap_q     <= 1'b1;
            done_q     <= 1'b1;
            timestep_q <= timestep_q + 16'd1;
          end
        end
        StSwap: begin
          if (restart) begin
            state_q <= StIssue;
            busy_q  <= 1'b1;
            if (!in_cim_busy) begin
              issue_valid_q <= 1'b1;
              rd_tag_q      <= '0;
              cnt_q         <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line; bubbles carry tag 0 so out_wb_tag is 0 when idle.
  always_ff @(posedge in_clk or posedge in_asyn_reset) begin
    if (in_asyn_reset) begin
      dl_valid_q <= '0;
      for (int i = 0; i < int'(pipe_latency); i++) begin
        dl_tag_q[i] <= '0;
      end
    end else begin
      dl_valid_q[0] <= issue_valid_q;
      dl_tag_q[0]   <= issue_valid_q ? rd_tag_q : '0;
      for (int i = 1; i < int'(pipe_latency); i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_tag_q[i]   <= dl_tag_q[i-1];
      end
    end
  end

  assign out_rd_tag      = rd_tag_q;
  assign out_issue_valid = issue_valid_q;
  assign out_wb_tag      = dl_tag_q[pipe_latency-1];
  assign out_sr_write_en = dl_valid_q[pipe_latency-1];
  assign out_swap        = swap_q;
  assign out_done        = done_q;
  assign out_busy        = busy_q;
  assign out_timestep    = timestep_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Directed bench for neuron_update_scheduler (numneurons=2, pipe_latency=3).
// A scoreboard queue holds each expected write-back (tag, due cycle) pushed
// at issue time and popped when the DUT asserts out_sr_write_en.
`timescale 1ns / 1ps

module tb_neuron_update_scheduler;

  localparam int unsigned NumNeurons  = 2;
  localparam int unsigned TagBits     = 1;
  localparam int unsigned PipeLatency = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               cim_busy;
  logic               fifo_empty;
  logic [TagBits-1:0] out_rd_tag;
  logic               out_issue_valid;
  logic [TagBits-1:0] out_wb_tag;
  logic               out_sr_write_en;
  logic               out_swap;
  logic               out_done;
  logic               out_busy;
  logic [15:0]        out_timestep;

  neuron_update_scheduler #(
    .numneurons  (NumNeurons),
    .tagbits     (TagBits),
    .pipe_latency(PipeLatency)
  ) dut (
    .in_clk         (clk),
    .in_asyn_reset  (rst),
    .in_start       (start),
    .in_cim_busy    (cim_busy),
    .in_fifo_empty  (fifo_empty),
    .out_rd_tag     (out_rd_tag),
    .out_issue_valid(out_issue_valid),
    .out_wb_tag     (out_wb_tag),
    .out_sr_write_en(out_sr_write_en),
    .out_swap       (out_swap),
    .out_done       (out_done),
    .out_busy       (out_busy),
    .out_timestep   (out_timestep)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    int due;
  } wb_t;

  wb_t sb[$];
  int  passed = 0;
  int  total  = 0;
  int  exp_tag = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
  endtask

  // Scoreboard: issued tags must follow 0..N-1 in order, and each must be
  // written back exactly PipeLatency cycles later, once.
  always @(negedge clk) begin
    wb_t e;
    wb_t n;
    if (rst) begin
      sb.delete();
      exp_tag = 0;
    end else begin
      if (out_sr_write_en === 1'b1) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", out_sr_write_en, 0);
        end else begin
          e = sb.pop_front();
          check("wb_tag", out_wb_tag, e.tag);
          check("wb_cycle", cyc, e.due);
        end
      end
      if (out_issue_valid === 1'b1) begin
        check("issue_tag", out_rd_tag, exp_tag);
        n.tag = exp_tag;
        n.due = cyc + PipeLatency;
        sb.push_back(n);
        exp_tag = (exp_tag + 1) % NumNeurons;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample outputs mid-cycle; a negative expectation means "don't care".
  task automatic sample(input string name, input int iv, input int tag, input int we,
                        input int wbt, input int sw, input int bz);
    @(negedge clk);
    if (iv >= 0)  check({name, ".issue_valid"}, out_issue_valid, iv);
    if (tag >= 0) check({name, ".rd_tag"}, out_rd_tag, tag);
    if (we >= 0)  check({name, ".sr_write_en"}, out_sr_write_en, we);
    if (wbt >= 0) check({name, ".wb_tag"}, out_wb_tag, wbt);
    if (sw >= 0) begin
      check({name, ".swap"}, out_swap, sw);
      check({name, ".done"}, out_done, sw);
    end
    if (bz >= 0)  check({name, ".busy"}, out_busy, bz);
  endtask

  // Returns at the falling edge of the swap cycle, or counts a failure.
  task automatic wait_swap(input string name, input int max_cycles);
    int found;
    found = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (out_swap === 1'b1) begin
        found = 1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cim_busy   = 1'b0;
    fifo_empty = 1'b1;
    sample("reset", 0, 0, 0, 0, 0, 0);
    check("reset.timestep", out_timestep, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic timestep, no stalls.
    start = 1'b1;
    sample("t1.c0", 0, -1, 0, -1, 0, 0);
    tick();
    start = 1'b0;
    sample("t1.c1", 1, 0, 0, 0, 0, 1);
    tick();
    sample("t1.c2", 1, 1, 0, 0, 0, 1);
    tick();
    sample("t1.c3", 0, 1, 0, 0, 0, 1);
    tick();
    sample("t1.c4", 0, -1, 1, 0, 0, 1);
    tick();
    sample("t1.c5", 0, -1, 1, 1, 0, 1);
    tick();
    sample("t1.c6", 0, -1, 0, 0, 0, 1);
    tick();
    sample("t1.c7", 0, -1, 0, 0, 1, 1);
    check("t1.timestep", out_timestep, 1);
    tick();
    sample("t1.c8", 0, -1, 0, 0, 0, 0);
    tick();

    // Busy stall for two cycles after tag 0 issues.
    start = 1'b1;
    sample("t2.d0", 0, -1, 0, -1, 0, 0);
    tick();
    start    = 1'b0;
    cim_busy = 1'b1;
    sample("t2.d1", 1, 0, 0, -1, 0, 1);
    tick();
    sample("t2.d2", 0, 0, 0, -1, 0, 1);
    tick();
    cim_busy = 1'b0;
    sample("t2.d3", 0, 0, 0, -1, 0, 1);
    tick();
    sample("t2.d4", 1, 1, 1, 0, 0, 1);
    tick();
    sample("t2.d5", 0, 1, 0, -1, 0, 1);
    tick();
    sample("t2.d6", 0, 1, 0, -1, 0, 1);
    tick();
    sample("t2.d7", 0, 1, 1, 1, 0, 1);
    tick();
    wait_swap("t2.swap_seen", 20);
    check("t2.timestep", out_timestep, 2);
    tick();

    // Spike FIFO not empty for 10 cycles in WAIT_SPIKES.
    fifo_empty = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      sample("t3.wait", 0, -1, 0, -1, 0, 1);
      tick();
    end
    fifo_empty = 1'b1;
    sample("t3.release", 0, -1, 0, -1, 0, 1);
    tick();
    sample("t3.swap", 0, -1, 0, -1, 1, 1);
    check("t3.timestep", out_timestep, 3);
    tick();

    // Reset in DRAIN with the tag 1 write-back still pending.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    sample("t4.f4", 0, -1, 1, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t4.rst.issue_valid", out_issue_valid, 0);
    check("t4.rst.rd_tag", out_rd_tag, 0);
    check("t4.rst.sr_write_en", out_sr_write_en, 0);
    check("t4.rst.busy", out_busy, 0);
    check("t4.rst.timestep", out_timestep, 0);
    tick();
    sample("t4.hold", 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample("t4.after", 0, 0, 0, 0, 0, 0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    sample("t4.clean", 1, 0, 0, -1, 0, 1);
    wait_swap("t4.swap_seen", 20);
    check("t4.timestep", out_timestep, 1);
    tick();

    // Hold in_start for three timesteps.
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_swap("t5.swap_seen", 40);
      if (k == 2) begin
        start = 1'b0;
      end else begin
        tick();
`ifdef SCHED_AUTORUN_EN
        sample("t5.restart", 1, 0, -1, -1, 0, 1);
`else
        sample("t5.idle_gap", 0, -1, -1, -1, 0, 0);
        tick();
        sample("t5.restart", 1, 0, -1, -1, 0, 1);
`endif
      end
    end
    check("t5.timestep", out_timestep, 4);
    tick();
    sample("t5.idle", 0, -1, 0, -1, 0, 0);
    tick();

    // Timestep counter wrap.
    force dut.timestep_q = 16'hFFFF;
    #1;
    release dut.timestep_q;
    #1;
    check("t6.preload", out_timestep, 16'hFFFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_swap("t6.swap_seen", 20);
    check("t6.wrap", out_timestep, 0);
    tick();
    sample("t6.idle", 0, -1, 0, -1, 0, 0);
    repeat (4) tick();

    check("end.scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
